vinst_q: RTL and testbench
==========================

# vinst_q

Instruction issue queue feeding the vector-instruction array controller. Buffers `sa_inst_t` words written by the host/sequencer and presents the head entry on the `inst`/`iavail`/`ird` interface the array controller consumes. The controller registers `iavail`, pulses `ird` for one cycle and samples `inst` in that same cycle. `vinst_q` is the source end of that handshake and pops exactly once per `ird` pulse.

## Interface
- `DEPTH`, 4, number of entries; power of two, ≥ 2
- `AW`, `$clog2(DEPTH)`, pointer width (derived; not overridden)

- `clk`  in  1  clock
- `reset`  in  1  synchronous, active-high
- `hvalid`  in  1  host write request
- `hinst`  in  `sa_inst_t`  host instruction word
- `hready`  out  1  queue can accept; equals `!full`
- `flush`  in  1  discard all queued entries
- `iavail`  out  1  head entry valid; equals `!empty`
- `ird`  in  1  one-cycle pop pulse from the array controller
- `inst`  out  `sa_inst_t`  head entry, `mem[rd_ptr]`
- `count`  out  `AW+1`  occupancy, 0..`DEPTH`
- `full`  out  1  `count == DEPTH`
- `empty`  out  1  `count == 0`
- `err`  out  1  sticky underflow flag: `ird` seen while empty

## Operation
- Storage: `DEPTH` × `sa_inst_t` registers; `wr_ptr` and `rd_ptr` are `AW` bits wide.
- Pointers wrap naturally modulo `DEPTH`; full and empty are decided by `count`, not pointer compare.
- Push happens when `hvalid & hready & !flush`:
  - `mem[wr_ptr] <= hinst`
  - `wr_ptr` increments.
- Pop happens when `ird & !empty & !flush`: `rd_ptr` increments. Storage is not cleared.
- Count update per cycle:
  - push only: `count + 1`
  - pop only: `count − 1`
  - push and pop together: `count` unchanged
  - neither: `count` unchanged
- Push and pop in the same cycle are legal at any `count` where each is individually allowed, including `count == 1`.
  - `hready` is low when full, so no push occurs at `DEPTH`, even if a pop happens that cycle.
  - There is no combinational path from `ird` to `hready`.
- Underflow: `ird & empty` → no pointer or count change, `err <= 1`. `err` holds until `reset`; `flush` does not clear it.
- `hvalid & !hready` → write dropped with no state change. Host must hold `hvalid`/`hinst` until accepted.
- `flush`:
  - next cycle `wr_ptr = rd_ptr = 0`, `count = 0`
  - overrides any same-cycle push and pop
  - `err` unaffected.
- Reset values: `wr_ptr = rd_ptr = 0`, `count = 0`, `empty = 1`, `full = 0`, `iavail = 0`, `hready = 1`, `err = 0`. `inst` reflects `mem[0]` with contents don't-care; storage is not reset.
- Reset mid-operation: all queued entries are lost; same-cycle push and pop are ignored.

## Timing
- `iavail`, `hready`, `full`, `empty` and `count` are pure decodes of registered `count`; no input-to-output combinational paths.
- `inst` is a mux of registered storage on registered `rd_ptr`; it is stable for the whole cycle in which `ird` is high.
- Write-to-available latency: push accepted at edge N → `iavail = 1` and `inst = hinst` in cycle N+1.
- Pop: after the `ird` cycle's edge, `inst` shows the next entry in the same cycle that `count` decrements.
- The controller samples `iavail` one cycle late. After the final pop, `iavail` falls one cycle before the controller sees it. The controller's busy interlock prevents a re-pop, so the queue need not model it. A stray `ird` is caught by `err`.
- Throughput: one push per cycle sustained; one pop per cycle accepted.

## Structure
- `sa_inst_t` comes from `proj_pkgs`; nothing new is added there.
- Add `LAP_IQ_DEPTH` (default 4) to `proj_pkgs` as the system-level `DEPTH` value.
- Single module; no sub-module. Storage is a flop array, not an SRAM macro (`DEPTH` is small).

## Test plan
- Reset, then idle 3 cycles → `count = 0`, `iavail = 0`, `hready = 1`, `err = 0`.
- Push A, B, C on consecutive cycles → `count` 1, 2, 3. `iavail` first high the cycle after the A push, with `inst = A`. Pulses of `ird` yield A, B, C in order; `count` ends at 0 and `iavail` drops after the C pop.
- Push 4 entries with `DEPTH = 4` → `full = 1`, `hready = 0`. A held fifth `hvalid` is dropped until one `ird`; the fifth word is then accepted the next cycle. Continue pushing and popping past the pointer wrap; output order is preserved.
- `count = 1` with push and `ird` in the same cycle → `count` stays 1; `inst` switches to the new word next cycle.
- `ird` while empty → `err = 1` and stays set through later pushes, pops and `flush`; `count` stays 0.
- `count = 3` with `flush` plus a same-cycle push and `ird` → next cycle `count = 0`, `iavail = 0`. A subsequent push is read back as the first entry at `inst`.

Source files
------------

// File: rtl/proj_pkgs.sv
// ---------------------------------------------------------------------------
// proj_pkgs
// System-wide types and sizing constants shared across the array subsystem.
//   sa_inst_t     : vector-instruction word issued to the array controller
//   LAP_IQ_DEPTH  : system-level depth of the vinst_q instruction queue
// ---------------------------------------------------------------------------
package proj_pkgs;

  // Vector-instruction word as consumed by the array controller.
  typedef struct packed {
    logic [3:0]  op;
    logic [3:0]  dst;
    logic [3:0]  src;
    logic [15:0] imm;
  } sa_inst_t;

  // Depth of the instruction issue queue in front of the array controller.
  localparam int LAP_IQ_DEPTH = 4;

endpackage

// File: rtl/vinst_q_pkg.sv
// ---------------------------------------------------------------------------
// vinst_q_pkg
// Local helpers for the instruction issue queue.
//   q_op_e   : classification of what the queue does in a given cycle
//   q_op()   : builds that classification from the qualified push/pop strobes
// ---------------------------------------------------------------------------
package vinst_q_pkg;

  // What happens to occupancy this cycle. OP_BOTH leaves count unchanged
  // while both pointers advance.
  typedef enum logic [1:0] {
    OP_NONE = 2'b00,
    OP_PUSH = 2'b01,
    OP_POP  = 2'b10,
    OP_BOTH = 2'b11
  } q_op_e;

  // Combine the already-qualified push and pop strobes into one op code.
  function automatic q_op_e q_op(input logic push, input logic pop);
    q_op_e op;
    op = OP_NONE;
    case ({pop, push})
      2'b01:   op = OP_PUSH;
      2'b10:   op = OP_POP;
      2'b11:   op = OP_BOTH;
      default: op = OP_NONE;
    endcase
    return op;
  endfunction

endpackage

// File: rtl/vinst_q_if.sv
// ---------------------------------------------------------------------------
// vinst_q_if
// Bundles the host write side and the array-controller read side of the
// instruction issue queue.
//   host side : hvalid, hinst -> queue ; hready <- queue ; flush -> queue
//   ctrl side : ird -> queue ; iavail, inst <- queue
//   status    : count, full, empty, err <- queue
// Modports:
//   slave  : the queue itself (vinst_q)
//   master : the surrounding logic driving host writes and controller pops
// ---------------------------------------------------------------------------
interface vinst_q_if
  import proj_pkgs::*;
#(
  parameter int DEPTH = LAP_IQ_DEPTH
);

  localparam int AW = $clog2(DEPTH);

  logic          hvalid;
  sa_inst_t      hinst;
  logic          hready;
  logic          flush;
  logic          iavail;
  logic          ird;
  sa_inst_t      inst;
  logic [AW:0]   count;
  logic          full;
  logic          empty;
  logic          err;

  modport slave (
    input  hvalid, hinst, flush, ird,
    output hready, iavail, inst, count, full, empty, err
  );

  modport master (
    output hvalid, hinst, flush, ird,
    input  hready, iavail, inst, count, full, empty, err
  );

endinterface

// File: rtl/vinst_q.sv
// ---------------------------------------------------------------------------
// vinst_q
// Instruction issue queue feeding the vector-instruction array controller.
// Host writes sa_inst_t words; the head entry is presented on inst/iavail,
// and the controller pops it with a one-cycle ird pulse, sampling inst in
// that same cycle.
// Ports:
//   clk    : clock
//   reset  : synchronous, active-high
//   q      : vinst_q_if.slave (hvalid/hinst/hready/flush, ird/iavail/inst,
//            count/full/empty/err)
// ---------------------------------------------------------------------------
module vinst_q
  import proj_pkgs::*;
  import vinst_q_pkg::*;
#(
  parameter int DEPTH = LAP_IQ_DEPTH
)(
  input  logic       clk,
  input  logic       reset,
  vinst_q_if.slave   q
);

  localparam int           AW       = $clog2(DEPTH);
  localparam logic [AW:0]  FULL_CNT = (AW+1)'(DEPTH);

  sa_inst_t     mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   cnt;
  logic          err_q;

  logic  is_full;
  logic  is_empty;
  logic  push;
  logic  pop;
  q_op_e op;

  // Status flags depend only on the registered count, so neither ird nor
  // hvalid has a combinational path to hready/iavail. Push and pop are each
  // qualified on their own flag, which makes a same-cycle push+pop legal at
  // any count where both are individually allowed; flush overrides both.
  always_comb begin
    is_full  = (cnt == FULL_CNT);
    is_empty = (cnt == '0);
    push     = q.hvalid & ~is_full  & ~q.flush;
    pop      = q.ird    & ~is_empty & ~q.flush;
    op       = q_op(push, pop);
  end

  // Pointer, occupancy and sticky-error state. Pointers wrap naturally
  // because DEPTH is a power of two. An ird seen while empty only raises
  // err; flush empties the queue but deliberately leaves err alone so a
  // controller protocol fault is not hidden by a later flush.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
      err_q  <= 1'b0;
    end else begin
      if (q.ird && is_empty) begin
        err_q <= 1'b1;
      end
      if (q.flush) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
        cnt    <= '0;
      end else begin
        case (op)
          OP_PUSH: begin
            wr_ptr <= wr_ptr + 1'b1;
            cnt    <= cnt + 1'b1;
          end
          OP_POP: begin
            rd_ptr <= rd_ptr + 1'b1;
            cnt    <= cnt - 1'b1;
          end
          OP_BOTH: begin
            wr_ptr <= wr_ptr + 1'b1;
            rd_ptr <= rd_ptr + 1'b1;
          end
          default: begin
          end
        endcase
      end
    end
  end

  // Storage is a plain flop array with no reset: after reset only the
  // pointers matter, and the head contents are don't-care until written.
  // A push coinciding with reset is dropped so storage never changes while
  // the queue is being cleared.
  always_ff @(posedge clk) begin
    if (push && !reset) begin
      mem[wr_ptr] <= q.hinst;
    end
  end

  // Output decodes: everything comes from registered state, and inst is a
  // mux of registered storage on the registered read pointer, so it is
  // stable for the entire ird cycle.
  always_comb begin
    q.hready = ~is_full;
    q.iavail = ~is_empty;
    q.full   = is_full;
    q.empty  = is_empty;
    q.count  = cnt;
    q.err    = err_q;
    q.inst   = mem[rd_ptr];
  end

  // Occupancy can never exceed DEPTH given the full/empty qualification.
  a_count_bound: assert property (@(posedge clk) disable iff (reset) cnt <= FULL_CNT);

endmodule

// File: tb/tb_vinst_q.sv
// ---------------------------------------------------------------------------
// tb_vinst_q
// Directed self-checking bench for vinst_q with DEPTH = 4. Inputs are driven
// 1 time unit after the rising edge and outputs are checked at the same
// point, i.e. they reflect the state registered at that edge.
// ---------------------------------------------------------------------------
module tb_vinst_q;
  import proj_pkgs::*;

  localparam int DEPTH = 4;

  logic clk;
  logic reset;

  int tests_run;
  int tests_failed;

  vinst_q_if #(.DEPTH(DEPTH)) qif ();

  vinst_q #(.DEPTH(DEPTH)) dut (
    .clk   (clk),
    .reset (reset),
    .q     (qif.slave)
  );

  // 10-unit clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Distinct instruction words used as stimulus
  localparam sa_inst_t W_A = 28'h1A2_0001;
  localparam sa_inst_t W_B = 28'h2B3_0002;
  localparam sa_inst_t W_C = 28'h3C4_0003;
  localparam sa_inst_t W_0 = 28'h401_1000;
  localparam sa_inst_t W_1 = 28'h512_1001;
  localparam sa_inst_t W_2 = 28'h623_1002;
  localparam sa_inst_t W_3 = 28'h734_1003;
  localparam sa_inst_t W_4 = 28'h845_1004;
  localparam sa_inst_t W_5 = 28'h956_1005;
  localparam sa_inst_t W_X = 28'hA67_2000;
  localparam sa_inst_t W_Y = 28'hB78_2001;
  localparam sa_inst_t W_Z = 28'hC89_3000;

  // Advance one clock and settle just past the edge
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    qif.hvalid = 1'b0;
    qif.hinst  = '0;
    qif.flush  = 1'b0;
    qif.ird    = 1'b0;
  endtask

  // Reset, then idle for three cycles
  task automatic test_reset();
    idle_inputs();
    reset = 1'b1;
    step();
    step();
    reset = 1'b0;
    repeat (3) step();
    tests_run++;
    if (qif.count !== 3'd0) begin
      tests_failed++;
      $display("[TB] FAIL reset_count: got %0d want 0", qif.count);
    end
    tests_run++;
    if (qif.iavail !== 1'b0 || qif.empty !== 1'b1 || qif.full !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL reset_flags: iavail=%b empty=%b full=%b want 0/1/0",
               qif.iavail, qif.empty, qif.full);
    end
    tests_run++;
    if (qif.hready !== 1'b1 || qif.err !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL reset_hready_err: hready=%b err=%b want 1/0", qif.hready, qif.err);
    end
  endtask

  // Push A, B, C back to back, then pop them in order
  task automatic test_fifo_order();
    sa_inst_t words [3];
    words[0] = W_A;
    words[1] = W_B;
    words[2] = W_C;
    for (int i = 0; i < 3; i++) begin
      qif.hvalid = 1'b1;
      qif.hinst  = words[i];
      step();
      tests_run++;
      if (qif.count !== 3'(i + 1)) begin
        tests_failed++;
        $display("[TB] FAIL push_count_%0d: got %0d want %0d", i, qif.count, i + 1);
      end
      tests_run++;
      if (qif.iavail !== 1'b1 || qif.inst !== W_A) begin
        tests_failed++;
        $display("[TB] FAIL push_head_%0d: iavail=%b inst=%h want 1/%h", i, qif.iavail, qif.inst, W_A);
      end
    end
    qif.hvalid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tests_run++;
      if (qif.inst !== words[i]) begin
        tests_failed++;
        $display("[TB] FAIL pop_order_%0d: got %h want %h", i, qif.inst, words[i]);
      end
      qif.ird = 1'b1;
      step();
      qif.ird = 1'b0;
      tests_run++;
      if (qif.count !== 3'(2 - i)) begin
        tests_failed++;
        $display("[TB] FAIL pop_count_%0d: got %0d want %0d", i, qif.count, 2 - i);
      end
      step();
    end
    tests_run++;
    if (qif.iavail !== 1'b0 || qif.empty !== 1'b1 || qif.err !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL drain_flags: iavail=%b empty=%b err=%b want 0/1/0",
               qif.iavail, qif.empty, qif.err);
    end
  endtask

  // Fill to DEPTH, hold a fifth write, pop once, then drain across the wrap
  task automatic test_full_wrap();
    sa_inst_t fill [4];
    sa_inst_t expect_q [4];
    fill[0] = W_0; fill[1] = W_1; fill[2] = W_2; fill[3] = W_3;
    for (int i = 0; i < 4; i++) begin
      qif.hvalid = 1'b1;
      qif.hinst  = fill[i];
      step();
    end
    tests_run++;
    if (qif.full !== 1'b1 || qif.hready !== 1'b0 || qif.count !== 3'd4) begin
      tests_failed++;
      $display("[TB] FAIL full_flags: full=%b hready=%b count=%0d want 1/0/4",
               qif.full, qif.hready, qif.count);
    end
    // Fifth word held while full must be dropped
    qif.hinst = W_4;
    step();
    step();
    tests_run++;
    if (qif.count !== 3'd4 || qif.inst !== W_0) begin
      tests_failed++;
      $display("[TB] FAIL full_drop: count=%0d inst=%h want 4/%h", qif.count, qif.inst, W_0);
    end
    // Pop while full: no push this cycle even though hvalid is held
    qif.ird = 1'b1;
    step();
    qif.ird = 1'b0;
    tests_run++;
    if (qif.count !== 3'd3 || qif.hready !== 1'b1 || qif.inst !== W_1) begin
      tests_failed++;
      $display("[TB] FAIL full_pop: count=%0d hready=%b inst=%h want 3/1/%h",
               qif.count, qif.hready, qif.inst, W_1);
    end
    // Held word accepted on the next cycle
    step();
    qif.hvalid = 1'b0;
    tests_run++;
    if (qif.count !== 3'd4 || qif.full !== 1'b1) begin
      tests_failed++;
      $display("[TB] FAIL held_accept: count=%0d full=%b want 4/1", qif.count, qif.full);
    end
    // Drain across the wrap in order, pulsing ird every other cycle
    expect_q[0] = W_1; expect_q[1] = W_2; expect_q[2] = W_3; expect_q[3] = W_4;
    for (int i = 0; i < 4; i++) begin
      tests_run++;
      if (qif.inst !== expect_q[i]) begin
        tests_failed++;
        $display("[TB] FAIL wrap_order_%0d: got %h want %h", i, qif.inst, expect_q[i]);
      end
      qif.ird = 1'b1;
      step();
      qif.ird = 1'b0;
      step();
    end
    // One more push/pop past the wrap
    qif.hvalid = 1'b1;
    qif.hinst  = W_5;
    step();
    qif.hvalid = 1'b0;
    tests_run++;
    if (qif.count !== 3'd1 || qif.inst !== W_5) begin
      tests_failed++;
      $display("[TB] FAIL wrap_push: count=%0d inst=%h want 1/%h", qif.count, qif.inst, W_5);
    end
    qif.ird = 1'b1;
    step();
    qif.ird = 1'b0;
    tests_run++;
    if (qif.count !== 3'd0 || qif.err !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL wrap_drain: count=%0d err=%b want 0/0", qif.count, qif.err);
    end
  endtask

  // Same-cycle push and pop at count == 1
  task automatic test_back_to_back();
    qif.hvalid = 1'b1;
    qif.hinst  = W_X;
    step();
    qif.hinst  = W_Y;
    qif.ird    = 1'b1;
    step();
    qif.hvalid = 1'b0;
    qif.ird    = 1'b0;
    tests_run++;
    if (qif.count !== 3'd1 || qif.inst !== W_Y || qif.iavail !== 1'b1) begin
      tests_failed++;
      $display("[TB] FAIL push_pop_cnt1: count=%0d inst=%h iavail=%b want 1/%h/1",
               qif.count, qif.inst, qif.iavail, W_Y);
    end
    qif.ird = 1'b1;
    step();
    qif.ird = 1'b0;
    tests_run++;
    if (qif.count !== 3'd0) begin
      tests_failed++;
      $display("[TB] FAIL push_pop_drain: count=%0d want 0", qif.count);
    end
  endtask

  // Flush at count == 3 with same-cycle push and ird
  task automatic test_flush();
    sa_inst_t words [3];
    words[0] = W_A; words[1] = W_B; words[2] = W_C;
    for (int i = 0; i < 3; i++) begin
      qif.hvalid = 1'b1;
      qif.hinst  = words[i];
      step();
    end
    qif.hinst = W_X;
    qif.ird   = 1'b1;
    qif.flush = 1'b1;
    step();
    idle_inputs();
    tests_run++;
    if (qif.count !== 3'd0 || qif.iavail !== 1'b0 || qif.hready !== 1'b1 || qif.err !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL flush_state: count=%0d iavail=%b hready=%b err=%b want 0/0/1/0",
               qif.count, qif.iavail, qif.hready, qif.err);
    end
    qif.hvalid = 1'b1;
    qif.hinst  = W_Z;
    step();
    qif.hvalid = 1'b0;
    tests_run++;
    if (qif.count !== 3'd1 || qif.inst !== W_Z) begin
      tests_failed++;
      $display("[TB] FAIL flush_repush: count=%0d inst=%h want 1/%h", qif.count, qif.inst, W_Z);
    end
    qif.ird = 1'b1;
    step();
    qif.ird = 1'b0;
  endtask

  // ird while empty sets a sticky err that survives push, pop and flush
  task automatic test_underflow();
    qif.ird = 1'b1;
    step();
    qif.ird = 1'b0;
    tests_run++;
    if (qif.err !== 1'b1 || qif.count !== 3'd0) begin
      tests_failed++;
      $display("[TB] FAIL underflow: err=%b count=%0d want 1/0", qif.err, qif.count);
    end
    qif.hvalid = 1'b1;
    qif.hinst  = W_A;
    step();
    qif.hvalid = 1'b0;
    qif.ird    = 1'b1;
    step();
    qif.ird    = 1'b0;
    qif.flush  = 1'b1;
    step();
    qif.flush  = 1'b0;
    step();
    tests_run++;
    if (qif.err !== 1'b1 || qif.count !== 3'd0) begin
      tests_failed++;
      $display("[TB] FAIL err_sticky: err=%b count=%0d want 1/0", qif.err, qif.count);
    end
    reset = 1'b1;
    step();
    reset = 1'b0;
    tests_run++;
    if (qif.err !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL err_reset: err=%b want 0", qif.err);
    end
  endtask

  initial begin
    tests_run    = 0;
    tests_failed = 0;
    reset        = 1'b1;
    idle_inputs();
    test_reset();
    test_fifo_order();
    test_full_wrap();
    test_back_to_back();
    test_flush();
    test_underflow();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
